dmem_responder: RTL and testbench

Data-memory responder serving the processor datapath's load/store port: accepts one word request (address, write data, byte enables) through a valid/ready handshake, performs it against an internal word array after a fixed parameterized latency, and returns read data plus an error flag through a second valid/ready handshake. It sits on the memory side of the datapath's ALUResult/WriteData/ReadData path. It replaces the zero-latency data memory so the control unit can be exercised with stalls.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and sizing helpers for the data-memory responder.
//   state_t     - responder FSM states (IDLE, WAIT, RESP)
//   WORD_W/BE_W - data word width and number of byte lanes
//   idx_width   - word-index width for a given DEPTH
//   cnt_width   - latency down-counter width for a given LATENCY
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // The counter only ever holds values 1..LATENCY-1.
    function automatic int cnt_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit word storage.
//   clk     - rising-edge clock
//   i_we    - write strobe (one word per cycle)
//   i_idx   - word index for both read and write
//   i_wdata - write data
//   i_be    - byte-lane enables for the write
//   o_rdata - combinational read of word i_idx
// Contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory responder for the datapath
// load/store port. One request is accepted in IDLE, committed against the
// word array LATENCY cycles later, and its result held until taken.
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   req_valid  - request present          req_ready - accepting (IDLE only)
//   req_we     - 1 store / 0 load         req_addr  - byte address
//   req_wdata  - store data               req_be    - store byte enables
//   rsp_valid  - response present         rsp_ready - requester takes response
//   rsp_rdata  - load data (0 for stores and errors)
//   rsp_err    - misaligned or out-of-range access
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state, w_next_state;
    logic [CNT_W-1:0]  r_cnt, w_next_cnt;
    logic              w_commit;

    logic              r_we;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_c_we;
    logic [WORD_W-1:0] w_c_addr;
    logic [WORD_W-1:0] w_c_wdata;
    logic [BE_W-1:0]   w_c_be;
    logic              w_err;
    logic [IDX_W-1:0]  w_idx;
    logic [WORD_W-1:0] w_arr_rdata;

    // With LATENCY=1 the commit happens on the accept edge itself, so the
    // operands come straight from the request port instead of the capture regs.
    always_comb begin
        w_c_we    = r_we;
        w_c_addr  = r_addr;
        w_c_wdata = r_wdata;
        w_c_be    = r_be;
        if (LATENCY == 1) begin
            w_c_we    = req_we;
            w_c_addr  = req_addr;
            w_c_wdata = req_wdata;
            w_c_be    = req_be;
        end
    end

    // Any set bit above the index is out of range; the index never wraps.
    assign w_err = (w_c_addr[1:0] != 2'b00) || (|w_c_addr[WORD_W-1:IDX_W+2]);
    assign w_idx = w_c_addr[IDX_W+1:2];

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit && w_c_we && !w_err),
        .i_idx   (w_idx),
        .i_wdata (w_c_wdata),
        .i_be    (w_c_be),
        .o_rdata (w_arr_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_next_state = WAIT;
                        w_next_cnt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                w_next_cnt = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    w_next_state = RESP;
                    w_commit     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_c_we) ? '0 : w_arr_rdata;
            end
        end
    end

    // Request capture: data only, sampled solely on the accept edge.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // Reset gates req_ready so nothing is offered while reset is held.
    assign req_ready = (r_state == IDLE) && reset;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder.
// Three instances share the clock and request payload: index 0 has
// LATENCY=1, index 1 LATENCY=2, index 2 LATENCY=3 (all DEPTH=64).
module tb_dmem_responder;

    logic        clk;
    logic        rst_n     [3];
    logic        req_valid [3];
    logic        rsp_ready [3];
    logic        req_ready [3];
    logic        rsp_valid [3];
    logic        rsp_err   [3];
    logic [31:0] rsp_rdata [3];

    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    int checks;
    int errors;

    dmem_responder #(.DEPTH(64), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(3)) u_lat3 (
        .clk(clk), .reset(rst_n[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full transaction on instance d; caller and return both sit 1 time unit
    // after a rising edge. lat counts cycles from the request cycle to the
    // first cycle showing rsp_valid.
    task automatic run_txn(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_be       = be;
        req_valid[d] = 1'b1;
        guard = 0;
        while (!req_ready[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            checks++; errors++;
            $display("FAIL accept_timeout dut=%0d req_ready stuck low", d);
        end
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata[d];
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
        end
        req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b0) begin errors++; $display("FAIL reset_req_ready dut=%0d got %b want 0", d, req_ready[d]); end
            checks++;
            if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid dut=%0d got %b want 0", d, rsp_valid[d]); end
            checks++;
            if (rsp_rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata dut=%0d got %h want 0", d, rsp_rdata[d]); end
            checks++;
            if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err dut=%0d got %b want 0", d, rsp_err[d]); end
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready dut=%0d got %b want 1", d, req_ready[d]); end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        run_txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, er, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL store_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL store_rsp got rdata=%h err=%b want 0/0", rd, er); end
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_0x10 got %h err=%b want deadbeef/0", rd, er); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        run_txn(1, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0001_load got %h want deadbeaa", rd); end
        run_txn(1, 1'b1, 32'h10, 32'h11223344, 4'b0000, rd, er, lat);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL be0000_err got %b want 0", er); end
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL be0000_load got %h want deadbeaa", rd); end
        run_txn(1, 1'b1, 32'hFC, 32'h0BADF00D, 4'b1111, rd, er, lat);
        run_txn(1, 1'b0, 32'hFC, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin errors++; $display("FAIL last_word got %h err=%b want 0badf00d/0", rd, er); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        run_txn(1, 1'b0, 32'h13, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL misaligned_load got %h err=%b want 0/1", rd, er); end
        run_txn(1, 1'b0, 32'h100, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b1) begin errors++; $display("FAIL oor_load got %h err=%b want 0/1", rd, er); end
        run_txn(1, 1'b1, 32'h110, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b want 1", er); end
        run_txn(1, 1'b1, 32'h40000010, 32'h55555555, 4'b1111, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL upper_bits_store_err got %b want 1", er); end
        run_txn(1, 1'b1, 32'h11, 32'h77777777, 4'b1111, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL misaligned_store_err got %b want 1", er); end
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEAA || er !== 1'b0) begin errors++; $display("FAIL reload_after_errors got %h err=%b want deadbeaa/0", rd, er); end
    endtask

    task automatic test_hold_response();
        logic [31:0] rd; logic er; int lat;
        req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_be = '0;
        req_valid[1] = 1'b1;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            req_valid[1] = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h10;
            req_wdata = 32'h01010101 * (i + 1);
            req_be    = 4'b1111;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== 32'hDEADBEAA) begin
                errors++; $display("FAIL hold_stable cyc=%0d got valid=%b rdata=%h want 1/deadbeaa", i, rsp_valid[1], rsp_rdata[1]);
            end
            checks++;
            if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL hold_req_ready cyc=%0d got %b want 0", i, req_ready[1]); end
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        checks++;
        if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL hold_handshake got valid=%b ready=%b want 0/1", rsp_valid[1], req_ready[1]);
        end
        run_txn(1, 1'b0, 32'h10, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEAA) begin errors++; $display("FAIL hold_no_store got %h want deadbeaa", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        run_txn(2, 1'b1, 32'h20, 32'h12345678, 4'b1111, rd, er, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL lat3_latency got %0d want 3", lat); end
        run_txn(2, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL lat3_load got %h want 12345678", rd); end
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFFFFFF; req_be = 4'b1111;
        req_valid[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        checks++;
        if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
            errors++; $display("FAIL wait_state got valid=%b ready=%b want 0/0", rsp_valid[2], req_ready[2]);
        end
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        checks++;
        if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0 || rsp_rdata[2] !== 32'h0 || rsp_err[2] !== 1'b0) begin
            errors++; $display("FAIL mid_reset got valid=%b ready=%b rdata=%h err=%b want 0/0/0/0",
                               rsp_valid[2], req_ready[2], rsp_rdata[2], rsp_err[2]);
        end
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
            errors++; $display("FAIL after_mid_reset got ready=%b valid=%b want 1/0", req_ready[2], rsp_valid[2]);
        end
        run_txn(2, 1'b0, 32'h20, 32'h0, 4'b0000, rd, er, lat);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL dropped_store got %h want 12345678", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er; int lat;
        logic exp_v;
        run_txn(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'b1111, rd, er, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL lat1_latency got %0d want 1", lat); end
        req_we = 1'b0; req_addr = 32'h4; req_wdata = '0; req_be = '0;
        req_valid[0] = 1'b1;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            exp_v = (i % 2 == 0);
            checks++;
            if (rsp_valid[0] !== exp_v || req_ready[0] !== !exp_v) begin
                errors++; $display("FAIL b2b_cycle cyc=%0d got valid=%b ready=%b want %b/%b", i, rsp_valid[0], req_ready[0], exp_v, !exp_v);
            end
            if (exp_v) begin
                checks++;
                if (rsp_rdata[0] !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rdata cyc=%0d got %h want cafef00d", i, rsp_rdata[0]); end
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_hold_response();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
